// File: rtl/fb_pkg.sv
// Shared types for the renderer-side frame buffer write path.
package fb_pkg;

    localparam int COLOR_W = 6;
    localparam int COORD_W = 10;

    // Write-port owner: either arbitrating pixel producers or sweeping a clear.
    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // One frame buffer pixel write; also used by the tile/sprite renderers.
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COLOR_W-1:0] dado;
    } pixel_t;

    // True when the pixel lands inside the visible screen. Coordinates are
    // compared at full width so out-of-range values never alias onto screen.
    function automatic logic pixel_on_screen(input pixel_t p,
                                             input int unsigned width,
                                             input int unsigned height);
        return (32'(p.x) < width) && (32'(p.y) < height);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. Grant is combinational from the valids; the
// priority pointer moves to the other requester after every accepted transfer.
module rr_arbiter2 (
    input  logic       renderer_clk,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       enable,
    input  logic       accept,
    output logic [1:0] grant
);

    // 0: requester 0 wins a tie, 1: requester 1 wins a tie.
    logic prio_reg;
    logic prio_next;

    // One-hot grant: a lone valid requester always wins, ties go to priority.
    always_comb begin
        grant = 2'b00;
        if (enable) begin
            unique case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = prio_reg ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    // After a transfer the requester that was not served gets the tie-break.
    always_comb begin
        prio_next = prio_reg;
        if (accept) begin
            prio_next = grant[0];
        end
    end

    // Priority pointer register; requester 0 holds priority out of reset.
    always_ff @(posedge renderer_clk) begin
        if (reset) begin
            prio_reg <= 1'b0;
        end else begin
            prio_reg <= prio_next;
        end
    end

endmodule

// File: rtl/fb_write_scheduler.sv
// Frame buffer write-port controller: full-screen clear sweep plus
// round-robin sharing of the port between the tile and sprite renderers.
// All frame buffer outputs come straight from registers.
module fb_write_scheduler
    import fb_pkg::*;
#(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480
) (
    input  logic               renderer_clk,
    input  logic               reset,

    input  logic               clear_start,
    input  logic [COLOR_W-1:0] clear_color,
    output logic               clear_busy,
    output logic               clear_done,

    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [COORD_W-1:0] req0_x,
    input  logic [COORD_W-1:0] req0_y,
    input  logic [COLOR_W-1:0] req0_dado,

    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [COORD_W-1:0] req1_x,
    input  logic [COORD_W-1:0] req1_y,
    input  logic [COLOR_W-1:0] req1_dado,

    output logic               renderer_write,
    output logic [COORD_W-1:0] renderer_x,
    output logic [COORD_W-1:0] renderer_y,
    output logic [COLOR_W-1:0] renderer_dado
);

    localparam int NUM_REQ = 2;
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(SCREEN_WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(SCREEN_HEIGHT - 1);

    state_t             state_reg, state_next;
    logic [COORD_W-1:0] cx_reg, cx_next;
    logic [COORD_W-1:0] cy_reg, cy_next;
    logic [COLOR_W-1:0] color_reg, color_next;
    pixel_t             out_pix_reg, out_pix_next;
    logic               write_reg, write_next;

    logic [NUM_REQ-1:0] valid_vec;
    logic [NUM_REQ-1:0] grant_vec;
    logic [NUM_REQ-1:0] accept_vec;
    pixel_t             req_pix [NUM_REQ];
    pixel_t             sel_pix;
    logic               arb_enable;
    logic               accept;
    logic               last_x;
    logic               last_pix;

    // Gather both requesters into indexable form.
    assign valid_vec = {req1_valid, req0_valid};
    assign req_pix[0] = {req0_x, req0_y, req0_dado};
    assign req_pix[1] = {req1_x, req1_y, req1_dado};

    // A clear request pre-empts arbitration in the very cycle it arrives.
    assign arb_enable = (state_reg == ST_ARB) && !clear_start;

    rr_arbiter2 u_arb (
        .renderer_clk (renderer_clk),
        .reset        (reset),
        .valid        (valid_vec),
        .enable       (arb_enable),
        .accept       (accept),
        .grant        (grant_vec)
    );

    // Handshake completes where a requester is both valid and granted.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_accept
        assign accept_vec[gi] = valid_vec[gi] & grant_vec[gi];
    end

    assign req0_ready = grant_vec[0];
    assign req1_ready = grant_vec[1];
    assign accept     = |accept_vec;
    assign sel_pix    = accept_vec[1] ? req_pix[1] : req_pix[0];

    // The counters always name the pixel currently on the output registers,
    // so the final-pixel test lines up with the final write.
    assign last_x     = (cx_reg == X_LAST);
    assign last_pix   = last_x && (cy_reg == Y_LAST);
    assign clear_busy = (state_reg == ST_CLEAR);
    assign clear_done = (state_reg == ST_CLEAR) && last_pix;

    assign renderer_write = write_reg;
    assign renderer_x     = out_pix_reg.x;
    assign renderer_y     = out_pix_reg.y;
    assign renderer_dado  = out_pix_reg.dado;

    // Next-state and next-output logic for both port owners.
    always_comb begin
        state_next   = state_reg;
        cx_next      = cx_reg;
        cy_next      = cy_reg;
        color_next   = color_reg;
        out_pix_next = out_pix_reg;
        write_next   = 1'b0;

        unique case (state_reg)
            ST_ARB: begin
                if (clear_start) begin
                    // Load the first sweep pixel now so it is written on the
                    // first CLEAR cycle.
                    state_next        = ST_CLEAR;
                    color_next        = clear_color;
                    cx_next           = '0;
                    cy_next           = '0;
                    write_next        = 1'b1;
                    out_pix_next.x    = '0;
                    out_pix_next.y    = '0;
                    out_pix_next.dado = clear_color;
                end else if (accept) begin
                    // Off-screen pixels complete the handshake but are dropped.
                    out_pix_next = sel_pix;
                    write_next   = pixel_on_screen(sel_pix,
                                                   unsigned'(SCREEN_WIDTH),
                                                   unsigned'(SCREEN_HEIGHT));
                end
            end

            ST_CLEAR: begin
                if (last_pix) begin
                    state_next = ST_ARB;
                    cx_next    = '0;
                    cy_next    = '0;
                end else begin
                    if (last_x) begin
                        cx_next = '0;
                        cy_next = cy_reg + 1'b1;
                    end else begin
                        cx_next = cx_reg + 1'b1;
                    end
                    write_next        = 1'b1;
                    out_pix_next.x    = cx_next;
                    out_pix_next.y    = cy_next;
                    out_pix_next.dado = color_reg;
                end
            end

            default: begin
                state_next = ST_ARB;
            end
        endcase
    end

    // State, sweep counters and frame buffer output registers.
    always_ff @(posedge renderer_clk) begin
        if (reset) begin
            state_reg   <= ST_ARB;
            cx_reg      <= '0;
            cy_reg      <= '0;
            color_reg   <= '0;
            out_pix_reg <= '0;
            write_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cx_reg      <= cx_next;
            cy_reg      <= cy_next;
            color_reg   <= color_next;
            out_pix_reg <= out_pix_next;
            write_reg   <= write_next;
        end
    end

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Scoreboard bench for fb_write_scheduler on a 4x3 screen.
module tb_fb_write_scheduler;

    localparam int W = 4;
    localparam int H = 3;

    logic       renderer_clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear_start = 1'b0;
    logic [5:0] clear_color = '0;
    logic       clear_busy, clear_done;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [9:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
    logic [5:0] req0_dado = '0, req1_dado = '0;
    logic       renderer_write;
    logic [9:0] renderer_x, renderer_y;
    logic [5:0] renderer_dado;

    fb_write_scheduler #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H)) dut (
        .renderer_clk   (renderer_clk),
        .reset          (reset),
        .clear_start    (clear_start),
        .clear_color    (clear_color),
        .clear_busy     (clear_busy),
        .clear_done     (clear_done),
        .req0_valid     (req0_valid),
        .req0_ready     (req0_ready),
        .req0_x         (req0_x),
        .req0_y         (req0_y),
        .req0_dado      (req0_dado),
        .req1_valid     (req1_valid),
        .req1_ready     (req1_ready),
        .req1_x         (req1_x),
        .req1_y         (req1_y),
        .req1_dado      (req1_dado),
        .renderer_write (renderer_write),
        .renderer_x     (renderer_x),
        .renderer_y     (renderer_y),
        .renderer_dado  (renderer_dado)
    );

    always #5 renderer_clk = ~renderer_clk;

    int unsigned cyc = 0;
    always @(posedge renderer_clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cycle;
        int          x;
        int          y;
        int          dado;
        bit          done;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    // Reference model state: who wins a tie, and how many sweep cycles remain.
    int   prio = 0;
    int   clear_left = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: every write must match the head of the scoreboard in content and cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge renderer_clk);
            if (renderer_write) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", renderer_write, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    $display("cyc %0d write x=%0d y=%0d dado=0x%0h done=%0b",
                             cyc, renderer_x, renderer_y, renderer_dado, clear_done);
                    check("write_cycle", cyc, e.cycle);
                    check("write_x", renderer_x, e.x);
                    check("write_y", renderer_y, e.y);
                    check("write_dado", renderer_dado, e.dado);
                    check("write_done", clear_done, e.done);
                end
            end else begin
                check("done_without_write", clear_done, 1'b0);
                if (exp_q.size() > 0 && exp_q[0].cycle <= cyc) begin
                    check("missing_write", renderer_write, 1'b1);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Drive one cycle of inputs, then predict the ready/busy response and any write.
    task automatic step(input bit v0, input int x0, input int y0, input int d0,
                        input bit v1, input int x1, input int y1, input int d1,
                        input bit cs, input int cc);
        bit         in_clear;
        logic [1:0] exp_ready;
        int         g, xs, ys, ds;
        @(negedge renderer_clk);
        #1;
        req0_valid = v0; req0_x = 10'(x0); req0_y = 10'(y0); req0_dado = 6'(d0);
        req1_valid = v1; req1_x = 10'(x1); req1_y = 10'(y1); req1_dado = 6'(d1);
        clear_start = cs; clear_color = 6'(cc);
        #1;
        in_clear  = (clear_left > 0);
        exp_ready = 2'b00;
        if (in_clear) clear_left--;
        if (!in_clear && cs) begin
            for (int i = 0; i < W * H; i++)
                exp_q.push_back('{cyc + 1 + i, i % W, i / W, cc, (i == W * H - 1)});
            clear_left = W * H;
        end else if (!in_clear && (v0 || v1)) begin
            g  = (v0 && v1) ? prio : (v0 ? 0 : 1);
            xs = g ? x1 : x0;
            ys = g ? y1 : y0;
            ds = g ? d1 : d0;
            exp_ready[g] = 1'b1;
            if (xs < W && ys < H) exp_q.push_back('{cyc + 1, xs, ys, ds, 1'b0});
            prio = 1 - g;
        end
        check("clear_busy", clear_busy, in_clear);
        check("ready", {req1_ready, req0_ready}, exp_ready);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Reset for one edge, then confirm every output is cleared.
    task automatic apply_reset();
        @(negedge renderer_clk);
        #1;
        reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; clear_start = 1'b0;
        exp_q.delete();
        clear_left = 0;
        prio = 0;
        @(negedge renderer_clk);
        #2;
        check("rst_write", renderer_write, 1'b0);
        check("rst_x", renderer_x, 0);
        check("rst_y", renderer_y, 0);
        check("rst_dado", renderer_dado, 0);
        check("rst_busy", clear_busy, 1'b0);
        check("rst_done", clear_done, 1'b0);
        check("rst_ready", {req1_ready, req0_ready}, 2'b00);
        reset = 1'b0;
    endtask

    initial begin
        int drain;
        apply_reset();
        idle(2);

        // Single request from the tile renderer.
        step(1, 1, 2, 'h15, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Both valid for four cycles: grants alternate starting at requester 0.
        apply_reset();
        for (int i = 0; i < 4; i++) step(1, i, 0, 'h10 + i, 1, i, 1, 'h20 + i, 0, 0);
        idle(2);

        // Full clear with requesters knocking throughout the sweep.
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h3F);
        for (int i = 0; i < W * H; i++) step(1, 2, 2, 'h01, 1, 3, 1, 'h02, (i == 4), 'h05);
        idle(2);

        // Clear wins over a simultaneous sprite request; sprite served right after.
        step(0, 0, 0, 0, 1, 2, 1, 'h2A, 1, 'h11);
        for (int i = 0; i < W * H + 2; i++) step(0, 0, 0, 0, 1, 2, 1, 'h2A, 0, 0);
        idle(2);

        // Off-screen pixels are accepted, dropped, and still move the priority.
        apply_reset();
        step(1, W, 0, 'h07, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 'h08, 1, 1, 1, 'h09, 0, 0);
        step(0, 0, 0, 0, 1, 0, H, 'h0A, 0, 0);
        step(1, 2, 0, 'h0B, 1, 3, 0, 'h0C, 0, 0);
        idle(2);

        // Reset during a sweep, then a fresh sweep must start at (0,0).
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h2C);
        idle(4);
        apply_reset();
        idle(2);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 'h1B);
        idle(W * H + 2);

        // Randomized traffic with occasional clears and out-of-range coordinates.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 9) < 6, $urandom_range(0, W + 1), $urandom_range(0, H + 1),
                 $urandom_range(0, 63),
                 $urandom_range(0, 9) < 6, $urandom_range(0, W + 1), $urandom_range(0, H + 1),
                 $urandom_range(0, 63),
                 $urandom_range(0, 79) == 0, $urandom_range(0, 63));
        end

        // Drain the scoreboard within a bounded number of cycles.
        drain = 0;
        while ((exp_q.size() > 0 || clear_left > 0) && drain < 40) begin
            idle(1);
            drain++;
        end
        idle(2);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fb_write_scheduler.md
# fb_write_scheduler

Renderer-side controller for the frame buffer write port. Sequences a full-screen clear sweep and shares the single write port between two pixel producers (tile renderer, sprite renderer) using round-robin arbitration with valid/ready handshakes. Drives the frame buffer's `renderer_write` / `renderer_dado` / `renderer_x` / `renderer_y` directly from registers, and runs entirely in the `renderer_clk` domain.

## Interface
- `SCREEN_WIDTH`, default 640: pixels per line; clear sweep x range is 0..SCREEN_WIDTH-1.
- `SCREEN_HEIGHT`, default 480: lines per frame; clear sweep y range is 0..SCREEN_HEIGHT-1.
- `renderer_clk`  in  1: the only clock.
- `reset`  in  1: synchronous, active-high.
- `clear_start`  in  1: single-cycle request to clear the whole buffer.
- `clear_color`  in  6: fill colour, sampled when `clear_start` is accepted.
- `clear_busy`  out  1: high while a sweep is in progress.
- `clear_done`  out  1: one-cycle pulse, coincident with the last clear write.
- `req0_valid`, `req1_valid`  in  1: pixel write request from requester 0 (tile) or 1 (sprite).
- `req0_ready`, `req1_ready`  out  1: grant; transfer occurs when valid && ready.
- `req0_x`, `req1_x`  in  10: pixel column.
- `req0_y`, `req1_y`  in  10: pixel row.
- `req0_dado`, `req1_dado`  in  6: pixel colour.
- `renderer_write`  out  1: frame buffer write strobe.
- `renderer_x`, `renderer_y`  out  10: frame buffer write address.
- `renderer_dado`  out  6: frame buffer write data.

## Operation
- States: ARB (default) and CLEAR.
- ARB:
  - `reqN_ready` is combinational: state==ARB && !clear_start && granted(N).
  - Grant rule: if only one requester is valid, it is granted. If both are valid, the one holding priority is granted.
  - Priority pointer toggles to the other requester after every accepted transfer. After reset, requester 0 holds priority.
  - A ready requester may see its grant withdrawn if its valid drops. There is no lock.
- Accepted transfer:
  - Next cycle, `renderer_write`=1 with the accepted x/y/dado.
  - If x ≥ SCREEN_WIDTH or y ≥ SCREEN_HEIGHT, the pixel is still accepted but `renderer_write` stays 0 (dropped). The priority pointer still toggles.
- `clear_start` in ARB:
  - Latch `clear_color` and set counters cx=cy=0.
  - Enter CLEAR next cycle. `clear_busy` rises that same cycle.
  - `clear_start` beats any simultaneous request; no request is accepted in that cycle.
- CLEAR:
  - One write per cycle: (cx, cy, latched colour).
  - cx increments. On cx==SCREEN_WIDTH-1, cx wraps to 0 and cy increments.
  - Both `reqN_ready` are held 0.
  - The write at (SCREEN_WIDTH-1, SCREEN_HEIGHT-1) pulses `clear_done` in the same cycle. `clear_busy` drops and the state returns to ARB on the following cycle.
  - `clear_start` during CLEAR is ignored; the sweep is not restarted.
- Reset (including mid-clear):
  - State returns to ARB; priority goes to requester 0; counters are cleared.
  - All outputs go to 0: `renderer_write`, `renderer_x`/`renderer_y`/`renderer_dado`, `clear_busy`, `clear_done`, `reqN_ready`.
  - An aborted sweep produces no `clear_done`.
- Widths:
  - Counters are 10 bits.
  - Comparisons use parameter values; no modular wrap of incoming coordinates.

## Timing
- Request accept to `renderer_write`: 1 cycle, registered.
- `clear_start` to first clear write: 1 cycle.
- Sweep length: exactly SCREEN_WIDTH×SCREEN_HEIGHT consecutive write cycles.
- `clear_done` is asserted together with the final write. First ARB acceptance is possible on the cycle after `clear_done`.
- Sustained throughput is 1 pixel/cycle in both states. With both requesters always valid, grants alternate 0,1,0,1…

## Structure
- Shared package `fb_pkg`:
  - `COLOR_W`=6, `COORD_W`=10.
  - State enum {ST_ARB, ST_CLEAR}.
  - Pixel struct {x, y, dado}, reused by the renderers.
- Sub-module `rr_arbiter2`:
  - Inputs: two valids, enable, accept.
  - Outputs: one-hot grant.
  - Holds the priority pointer.
- The top level holds the FSM, clear counters and output registers.

## Test plan
All scenarios use SCREEN_WIDTH=4, SCREEN_HEIGHT=3.
- Reset then idle → all outputs 0; assert `req0_valid` with (1,2,0x15) → `req0_ready`=1, next cycle `renderer_write`=1, x=1, y=2, dado=0x15.
- Both valid continuously for 4 cycles → accepts in order 0,1,0,1; four consecutive writes carrying the matching data.
- `clear_start` with colour 0x3F → 12 consecutive writes (0,0),(1,0)…(3,2) with dado 0x3F; `clear_done` only on the (3,2) write; ready held 0 throughout.
- `clear_start` and `req1_valid` in the same cycle → `req1_ready`=0; sweep runs; req1 is accepted on the first cycle after `clear_done`.
- Request at (4,0) and at (0,3) → both accepted (ready=1), `renderer_write` stays 0, priority pointer toggles.
- `reset` asserted mid-sweep at write 5 → next cycle all outputs 0, no `clear_done`; a new `clear_start` restarts at (0,0).
